// File: rtl/ddr_ctrl_pkg.sv
// ddr_ctrl_pkg -- definitions shared by the DDR read and write controllers.
//   state_e      : controller FSM encodings (IDLE/RD_REQ/READ/WAIT_DATA)
//   CMD_WR/CMD_RD: MIG app_cmd opcodes
//   DEF_*        : default frame size, burst length and address step
//   next_addr()  : frame address advance with wrap to 0 at the end of the frame
package ddr_ctrl_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;

    localparam int DEF_TOTAL_PIXEL = 1024 * 768;
    localparam int DEF_BURST_LEN   = 64;
    localparam int DEF_ADDR_STEP   = 8;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_REQ    = 2'd1,
        READ      = 2'd2,
        WAIT_DATA = 2'd3
    } state_e;

    // The last legal address of a frame is total-step; the next one is 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input int step,
                                                    input int total);
        if (addr == ADDR_W'(total - step))
            return '0;
        return addr + ADDR_W'(step);
    endfunction

endpackage

// File: rtl/ddr_burst_cnt.sv
// ddr_burst_cnt -- burst position counter, 0..MAX-1.
//   ui_clk : clock
//   rst    : asynchronous active-high reset
//   inc    : advance by one
//   clr    : return to 0 (wins over inc)
//   count  : current position
//   last   : position is MAX-1
module ddr_burst_cnt #(
    parameter int MAX = 64,
    parameter int W   = 6
) (
    input  logic         ui_clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        // NOTE: sequential state is updated with <= so all flops see pre-edge values.
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == W'(MAX - 1));

endmodule

// File: rtl/ddr_rd_ctrl.sv
// ddr_rd_ctrl -- DDR read controller between the arbiter/frame sequencer and the MIG app port.
// On rd_start it requests the shared user port, issues BURST_LEN read commands at a
// wrapping frame address and forwards the returned beats to the downstream read FIFO.
//   ui_clk, rst          : MIG user clock, asynchronous active-high reset
//   rd_start             : start one burst (only looked at in IDLE)
//   rd_req / rd_ack      : arbiter request / grant
//   rd_done              : 1-cycle pulse with the final forwarded beat
//   rd_busy              : burst in progress (READ or WAIT_DATA)
//   fifo_afull           : downstream almost full, holds off new commands
//   app_rdy/app_en/app_cmd/app_addr : MIG command handshake
//   app_rd_data/_valid/_end         : MIG read return (_end unused; beats are counted)
//   rd_ddr_data/rd_ddr_valid        : registered data and write enable to the FIFO
// Build option RD_BEAT_ERR_EN: adds sticky output rd_err, set when a beat arrives with
// no outstanding command (cnt_data == cnt_cmd outside WAIT_DATA).
module ddr_rd_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int TOTAL_PIXEL = DEF_TOTAL_PIXEL,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int ADDR_STEP   = DEF_ADDR_STEP
) (
    input  logic          ui_clk,
    input  logic          rst,
    input  logic          rd_start,
    output logic          rd_req,
    input  logic          rd_ack,
    output logic          rd_done,
    output logic          rd_busy,
`ifdef RD_BEAT_ERR_EN
    output logic          rd_err,
`endif
    input  logic          fifo_afull,
    input  logic          app_rdy,
    output logic          app_en,
    output logic [2:0]    app_cmd,
    output logic [28:0]   app_addr,
    input  logic [255:0]  app_rd_data,
    input  logic          app_rd_data_valid,
    input  logic          app_rd_data_end,
    output logic [255:0]  rd_ddr_data,
    output logic          rd_ddr_valid
);

    localparam int CNT_W = $clog2(BURST_LEN);

    state_e               state_q, state_d;
    logic                 rd_req_q, rd_req_d;
    logic                 rd_done_q, rd_done_d;
    logic                 rd_busy_q, rd_busy_d;
    logic                 app_en_q, app_en_d;
    logic [ADDR_W-1:0]    app_addr_q, app_addr_d;
    logic [DATA_W-1:0]    rd_ddr_data_q, rd_ddr_data_d;
    logic                 rd_ddr_valid_q, rd_ddr_valid_d;

    logic [CNT_W-1:0]     cnt_cmd, cnt_data;
    logic                 cmd_last, data_last;
    logic                 cmd_acc, cmd_done, beat, data_done;

    assign cmd_acc   = app_en_q & app_rdy;
    assign cmd_done  = cmd_acc & cmd_last;
    // Beats outside READ/WAIT_DATA belong to no burst of ours and are dropped.
    assign beat      = app_rd_data_valid & rd_busy_q;
    assign data_done = beat & data_last;

    ddr_burst_cnt #(.MAX(BURST_LEN), .W(CNT_W)) u_cnt_cmd (
        .ui_clk (ui_clk),
        .rst    (rst),
        .inc    (cmd_acc),
        .clr    (cmd_done),
        .count  (cnt_cmd),
        .last   (cmd_last)
    );

    ddr_burst_cnt #(.MAX(BURST_LEN), .W(CNT_W)) u_cnt_data (
        .ui_clk (ui_clk),
        .rst    (rst),
        .inc    (beat),
        .clr    (data_done),
        .count  (cnt_data),
        .last   (data_last)
    );

    always_comb begin
        state_d        = state_q;
        rd_req_d       = rd_req_q;
        app_en_d       = app_en_q;
        app_addr_d     = app_addr_q;
        rd_ddr_data_d  = rd_ddr_data_q;
        rd_ddr_valid_d = beat;
        rd_done_d      = data_done;

        case (state_q)
            IDLE: if (rd_start) begin
                state_d  = RD_REQ;
                rd_req_d = 1'b1;
            end
            RD_REQ: if (rd_ack) begin
                state_d  = READ;
                rd_req_d = 1'b0;
            end
            // The final beat can coincide with the final accept only with a zero-latency
            // memory, but the FSM must still not park in WAIT_DATA waiting for it.
            READ: if (cmd_done)
                state_d = data_done ? IDLE : WAIT_DATA;
            WAIT_DATA: if (data_done)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cmd_acc)
            app_addr_d = next_addr(app_addr_q, ADDR_STEP, TOTAL_PIXEL);

        // A pending command is held regardless of fifo_afull; a new one is only
        // offered when the FIFO has room and the burst is not finished.
        if (!app_en_q || app_rdy)
            app_en_d = (state_q == READ) && !cmd_done && !fifo_afull;

        if (beat)
            rd_ddr_data_d = app_rd_data;

        rd_busy_d = (state_d == READ) || (state_d == WAIT_DATA);
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_req_q       <= 1'b0;
            rd_done_q      <= 1'b0;
            rd_busy_q      <= 1'b0;
            app_en_q       <= 1'b0;
            app_addr_q     <= '0;
            // NOTE: the wide data register is reset too so the FIFO port never shows stale data after rst.
            rd_ddr_data_q  <= '0;
            rd_ddr_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_req_q       <= rd_req_d;
            rd_done_q      <= rd_done_d;
            rd_busy_q      <= rd_busy_d;
            app_en_q       <= app_en_d;
            app_addr_q     <= app_addr_d;
            rd_ddr_data_q  <= rd_ddr_data_d;
            rd_ddr_valid_q <= rd_ddr_valid_d;
        end
    end

`ifdef RD_BEAT_ERR_EN
    logic rd_err_q, rd_err_d;

    // In WAIT_DATA every command has been issued, so a beat there is always owed.
    always_comb begin
        rd_err_d = rd_err_q;
        if (app_rd_data_valid && (state_q != WAIT_DATA) && (cnt_data == cnt_cmd))
            rd_err_d = 1'b1;
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst)
            rd_err_q <= 1'b0;
        else
            rd_err_q <= rd_err_d;
    end

    assign rd_err = rd_err_q;

    logic unused_sink;
    assign unused_sink = app_rd_data_end;
`else
    // Without the beat check the raw counts only feed the last-position flags.
    logic unused_sink;
    assign unused_sink = ^{app_rd_data_end, cnt_cmd, cnt_data};
`endif

    assign rd_req       = rd_req_q;
    assign rd_done      = rd_done_q;
    assign rd_busy      = rd_busy_q;
    assign app_en       = app_en_q;
    assign app_cmd      = CMD_RD;
    assign app_addr     = app_addr_q;
    assign rd_ddr_data  = rd_ddr_data_q;
    assign rd_ddr_valid = rd_ddr_valid_q;

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// tb_ddr_rd_ctrl -- bench for ddr_rd_ctrl with a MIG model (fixed 10-cycle read latency)
// and a scoreboard of expected FIFO beats. A small frame (TB_TOTAL) keeps the address
// wrap reachable in a few bursts.
module tb_ddr_rd_ctrl;

    localparam int TB_TOTAL = 1040;
    localparam int BL       = 64;
    localparam int STEP     = 8;
    localparam int LATENCY  = 10;

    logic          ui_clk;
    logic          rst;
    logic          rd_start, rd_req, rd_ack, rd_done, rd_busy;
    logic          fifo_afull, app_rdy, app_en;
    logic [2:0]    app_cmd;
    logic [28:0]   app_addr;
    logic [255:0]  app_rd_data, rd_ddr_data;
    logic          app_rd_data_valid, app_rd_data_end, rd_ddr_valid;
`ifdef RD_BEAT_ERR_EN
    logic          rd_err;
`endif

    ddr_rd_ctrl #(.TOTAL_PIXEL(TB_TOTAL), .BURST_LEN(BL), .ADDR_STEP(STEP)) dut (
        .ui_clk            (ui_clk),
        .rst               (rst),
        .rd_start          (rd_start),
        .rd_req            (rd_req),
        .rd_ack            (rd_ack),
        .rd_done           (rd_done),
        .rd_busy           (rd_busy),
`ifdef RD_BEAT_ERR_EN
        .rd_err            (rd_err),
`endif
        .fifo_afull        (fifo_afull),
        .app_rdy           (app_rdy),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
        .rd_ddr_data       (rd_ddr_data),
        .rd_ddr_valid      (rd_ddr_valid)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    typedef struct {
        int           due;
        logic [255:0] data;
        bit           stray;
    } beat_t;

    beat_t        sched[$];
    logic [255:0] exp_q[$];
    int           acc_log[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0, n_acc = 0, n_valid = 0, n_done = 0, n_stray = 0;
    int exp_addr = 0;
    int rdy_mode = 0;     // 0: always ready, 1: random, 2: never ready
    bit extra_beat = 0;
    bit en_prev = 0, en_pend = 0;
    logic afull_at_edge = 1'b0;
    int acc0, val0, done0;

    always @(posedge ui_clk) afull_at_edge <= fifo_afull;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // MIG model + output scoreboard: samples DUT outputs on the falling edge, then
    // drives app_rdy and read beats for the next rising edge.
    initial begin : mig_model
        beat_t b;
        app_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0; app_rd_data_end = 1'b0;
        forever begin
            @(negedge ui_clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                foreach (sched[i]) sched[i].stray = 1'b1;
                exp_addr = 0; en_prev = 0; en_pend = 0;
            end else begin
                if (rd_ddr_valid === 1'b1) begin
                    n_valid++;
                    checks++;
                    if (exp_q.size() == 0)
                        begin errors++; $display("FAIL unexpected_valid: rd_ddr_valid=1 expected 0 (no beat owed)"); end
                    else begin
                        logic [255:0] e;
                        e = exp_q.pop_front();
                        if (rd_ddr_data !== e)
                            begin errors++; $display("FAIL rd_ddr_data: got %h expected %h", rd_ddr_data, e); end
                    end
                end
                if (rd_done === 1'b1) begin
                    n_done++;
                    checks++;
                    if (rd_ddr_valid !== 1'b1)
                        begin errors++; $display("FAIL done_align: rd_ddr_valid=%b expected 1 with rd_done", rd_ddr_valid); end
                end
                if (en_pend) begin
                    checks++;
                    if (app_en !== 1'b1)
                        begin errors++; $display("FAIL en_dropped: app_en=%b expected 1 (unaccepted)", app_en); end
                end
                if (app_en === 1'b1 && !en_prev) begin
                    checks++;
                    if (afull_at_edge === 1'b1)
                        begin errors++; $display("FAIL en_rise_afull: app_en rose=1 expected 0 while fifo_afull"); end
                end
            end

            case (rdy_mode)
                0:       app_rdy = 1'b1;
                1:       app_rdy = 1'($urandom_range(0, 1));
                default: app_rdy = 1'b0;
            endcase

            if (!rst && app_en === 1'b1 && app_rdy) begin
                checks++;
                if (app_addr !== 29'(exp_addr))
                    begin errors++; $display("FAIL app_addr: got %0d expected %0d", app_addr, exp_addr); end
                acc_log.push_back(exp_addr);
                exp_addr = (exp_addr == TB_TOTAL - STEP) ? 0 : exp_addr + STEP;
                n_acc++;
                b.due = cyc + LATENCY; b.data = rand256(); b.stray = 1'b0;
                sched.push_back(b);
            end
            if (!rst) begin
                en_pend = (app_en === 1'b1) && !app_rdy;
                en_prev = (app_en === 1'b1);
            end

            if (sched.size() > 0 && sched[0].due <= cyc) begin
                b = sched.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data = b.data;
                if (b.stray) n_stray++;
                else         exp_q.push_back(b.data);
            end else if (extra_beat) begin
                extra_beat = 0;
                app_rd_data_valid = 1'b1;
                app_rd_data = rand256();
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = rand256();
            end
        end
    end

    task automatic tick();
        @(negedge ui_clk); #1;
    endtask

    task automatic start_burst(input int ack_delay);
        acc0 = n_acc; val0 = n_valid; done0 = n_done;
        acc_log.delete();
        tick(); rd_start = 1'b1;
        tick(); rd_start = 1'b0;
        checks++;
        if (rd_req !== 1'b1) begin errors++; $display("FAIL req_set: rd_req=%b expected 1", rd_req); end
        repeat (ack_delay) tick();
        checks++;
        if (rd_req !== 1'b1 || rd_busy !== 1'b0)
            begin errors++; $display("FAIL req_held: rd_req=%b rd_busy=%b expected 1 0", rd_req, rd_busy); end
        rd_ack = 1'b1;
        tick(); rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || rd_busy !== 1'b1)
            begin errors++; $display("FAIL granted: rd_req=%b rd_busy=%b expected 0 1", rd_req, rd_busy); end
    endtask

    task automatic finish_burst(input string tag);
        bit got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (n_done != done0) begin got = 1; break; end
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_timeout: rd_done seen=0 expected 1", tag); end
        tick();
        checks++;
        if (rd_busy !== 1'b0) begin errors++; $display("FAIL %s_busy: rd_busy=%b expected 0", tag, rd_busy); end
        repeat (20) tick();
        checks++;
        if (n_acc - acc0 != BL) begin errors++; $display("FAIL %s_accepts: got %0d expected %0d", tag, n_acc - acc0, BL); end
        checks++;
        if (n_valid - val0 != BL) begin errors++; $display("FAIL %s_beats: got %0d expected %0d", tag, n_valid - val0, BL); end
        checks++;
        if (n_done - done0 != 1) begin errors++; $display("FAIL %s_dones: got %0d expected 1", tag, n_done - done0); end
        checks++;
        if (exp_q.size() != 0 || rd_req !== 1'b0)
            begin errors++; $display("FAIL %s_idle: pending=%0d rd_req=%b expected 0 0", tag, exp_q.size(), rd_req); end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rd_req, rd_done, rd_busy, app_en, rd_ddr_valid} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {rd_req, rd_done, rd_busy, app_en, rd_ddr_valid}); end
        checks++;
        if (app_addr !== 29'd0 || rd_ddr_data !== 256'd0)
            begin errors++; $display("FAIL reset_data: addr=%0d data=%h expected 0 0", app_addr, rd_ddr_data); end
        checks++;
        if (app_cmd !== 3'b001) begin errors++; $display("FAIL app_cmd: got %b expected 001", app_cmd); end
`ifdef RD_BEAT_ERR_EN
        checks++;
        if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_err: rd_err=%b expected 0", rd_err); end
`endif
        rst = 1'b0;
        repeat (2) tick();
        rd_ack = 1'b1;
        tick(); rd_ack = 1'b0;
        tick();
        checks++;
        if (rd_req !== 1'b0 || rd_busy !== 1'b0 || app_en !== 1'b0)
            begin errors++; $display("FAIL stray_ack: req=%b busy=%b en=%b expected 0 0 0", rd_req, rd_busy, app_en); end
    endtask

    task automatic test_basic();
        start_burst(3);
        repeat (5) tick();
        rd_start = 1'b1; rd_ack = 1'b1;      // both must be ignored mid-burst
        tick(); rd_start = 1'b0; rd_ack = 1'b0;
        finish_burst("basic");
        checks++;
        if (acc_log.size() != BL || acc_log[0] != 0 || acc_log[BL-1] != 504)
            begin errors++; $display("FAIL basic_addr_range: first=%0d last=%0d expected 0 504", acc_log[0], acc_log[acc_log.size()-1]); end
    endtask

    task automatic test_random_rdy();
        rdy_mode = 1;
        start_burst(1);
        finish_burst("rand_rdy");
        rdy_mode = 0;
    endtask

    task automatic test_wrap();
        tick();
        checks++;
        if (app_addr !== 29'(TB_TOTAL - 16))
            begin errors++; $display("FAIL wrap_preload: addr=%0d expected %0d", app_addr, TB_TOTAL - 16); end
        start_burst(2);
        finish_burst("wrap");
        checks++;
        if (acc_log.size() < 4 || acc_log[0] != TB_TOTAL - 16 || acc_log[1] != TB_TOTAL - 8 ||
            acc_log[2] != 0 || acc_log[3] != 8)
            begin errors++; $display("FAIL wrap_seq: got %0d %0d %0d %0d expected %0d %0d 0 8",
                                     acc_log[0], acc_log[1], acc_log[2], acc_log[3], TB_TOTAL - 16, TB_TOTAL - 8); end
    endtask

    task automatic test_afull();
        int win0;
        bit reached = 0;
        start_burst(1);
        for (int i = 0; i < 200; i++) begin
            if (n_acc - acc0 >= 10) begin reached = 1; break; end
            tick();
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL afull_reach: accepts=%0d expected 10", n_acc - acc0); end
        rdy_mode = 2;
        tick(); fifo_afull = 1'b1; win0 = n_acc;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (app_en !== 1'b1) begin errors++; $display("FAIL afull_pending: app_en=%b expected 1", app_en); end
            end
            if (i == 5) rdy_mode = 0;
        end
        checks++;
        if (n_acc - win0 != 1 || app_en !== 1'b0)
            begin errors++; $display("FAIL afull_window: accepts=%0d app_en=%b expected 1 0", n_acc - win0, app_en); end
        fifo_afull = 1'b0;
        finish_burst("afull");
    endtask

`ifdef RD_BEAT_ERR_EN
    task automatic test_beat_err();
        start_burst(1);
        finish_burst("err_burst");
        checks++;
        if (rd_err !== 1'b0) begin errors++; $display("FAIL err_clean: rd_err=%b expected 0", rd_err); end
        extra_beat = 1;
        repeat (3) tick();
        checks++;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL err_set: rd_err=%b expected 1", rd_err); end
        repeat (10) tick();
        checks++;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky: rd_err=%b expected 1", rd_err); end
        rst = 1'b1; #1;
        checks++;
        if (rd_err !== 1'b0) begin errors++; $display("FAIL err_clear: rd_err=%b expected 0", rd_err); end
        tick(); rst = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        int stray0;
        bit reached = 0;
        start_burst(1);
        for (int i = 0; i < 200; i++) begin
            if (n_acc - acc0 >= 30) begin reached = 1; break; end
            tick();
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL mid_reach: accepts=%0d expected 30", n_acc - acc0); end
        stray0 = n_stray;
        rst = 1'b1; #1;
        checks++;
        if ({rd_req, rd_done, rd_busy, app_en, rd_ddr_valid} !== 5'b0 || app_addr !== 29'd0)
            begin errors++; $display("FAIL mid_rst_outputs: ctrl=%b addr=%0d expected 00000 0",
                                     {rd_req, rd_done, rd_busy, app_en, rd_ddr_valid}, app_addr); end
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 50 && sched.size() > 0; i++) tick();
        repeat (3) tick();
        checks++;
        if (sched.size() != 0 || n_stray - stray0 == 0)
            begin errors++; $display("FAIL mid_strays: left=%0d seen=%0d expected 0 >0", sched.size(), n_stray - stray0); end
        checks++;
        if (rd_busy !== 1'b0) begin errors++; $display("FAIL mid_idle: rd_busy=%b expected 0", rd_busy); end
        start_burst(2);
        finish_burst("after_rst");
        checks++;
        if (acc_log.size() == 0 || acc_log[0] != 0)
            begin errors++; $display("FAIL after_rst_addr: first=%0d expected 0", acc_log.size() ? acc_log[0] : -1); end
    endtask

    initial begin : main
        rst = 1'b0; rd_start = 1'b0; rd_ack = 1'b0; fifo_afull = 1'b0;
        test_reset();
        test_basic();
        test_random_rdy();
        test_wrap();
        test_afull();
`ifdef RD_BEAT_ERR_EN
        test_beat_err();
`endif
        test_reset_mid();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1);
    end

endmodule
